// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - single-outstanding load/store responder over a word RAM with big-endian lanes
module data_memory_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10,
  parameter int LATENCY       = 2
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [DATA_WIDTH-1:0] reqAddress,
  input  logic [1:0]            reqSize,
  input  logic                  reqSigned,
  input  logic [DATA_WIDTH-1:0] reqWriteData,
  output logic                  respValid,
  input  logic                  respReady,
  output logic [DATA_WIDTH-1:0] respReadData,
  output logic                  respError
);

  localparam int AW = ADDRESS_WIDTH + 2;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESPOND} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [3:0]              r_count;
  logic                    r_write;
  logic [AW-1:0]           r_addr;
  logic [1:0]              r_size;
  logic                    r_signed;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;
  logic [DATA_WIDTH-1:0]   r_mem [0:(2**ADDRESS_WIDTH)-1];

  logic                    w_accept;
  logic                    w_commit;
  logic                    w_cmd_write;
  logic [AW-1:0]           w_cmd_addr;
  logic [1:0]              w_cmd_size;
  logic                    w_cmd_signed;
  logic [DATA_WIDTH-1:0]   w_cmd_wdata;
  logic [ADDRESS_WIDTH-1:0] w_index;
  logic [1:0]              w_off;
  logic                    w_error;
  logic [4:0]              w_shift;
  logic [DATA_WIDTH-1:0]   w_mask;
  logic [DATA_WIDTH-1:0]   w_old;
  logic [DATA_WIDTH-1:0]   w_lane;
  logic [DATA_WIDTH-1:0]   w_load;
  logic [DATA_WIDTH-1:0]   w_wr_word;
  logic [DATA_WIDTH-1:0]   w_resp_data;
  logic                    w_unused;

  // Address bits above the word index only alias onto the same words.
  assign w_unused = &{1'b0, reqAddress[DATA_WIDTH-1:AW]};

  assign w_accept  = reqValid & reqReady;
  assign respValid = (r_state == S_RESPOND);
  assign respReadData = r_rdata;
  assign respError    = r_err;

  // With LATENCY==1 the commit edge is the accept edge, so the live request is used instead of the latch.
  assign w_cmd_write  = (r_state == S_IDLE) ? reqWrite           : r_write;
  assign w_cmd_addr   = (r_state == S_IDLE) ? reqAddress[AW-1:0] : r_addr;
  assign w_cmd_size   = (r_state == S_IDLE) ? reqSize            : r_size;
  assign w_cmd_signed = (r_state == S_IDLE) ? reqSigned          : r_signed;
  assign w_cmd_wdata  = (r_state == S_IDLE) ? reqWriteData       : r_wdata;

  assign w_index  = w_cmd_addr[AW-1:2];
  assign w_off    = w_cmd_addr[1:0];
  assign w_error  = (w_cmd_size == 2'd3) ||
                    ((w_cmd_size == 2'd1) && w_off[0]) ||
                    ((w_cmd_size == 2'd2) && (w_off != 2'd0));
  assign w_commit = resetN && (w_next_state == S_RESPOND) && (r_state != S_RESPOND);

  // Next-state and request-ready decode.
  always_comb begin
    w_next_state = r_state;
    reqReady     = 1'b0;
    case (r_state)
      S_IDLE: begin
        reqReady = resetN;
        if (reqValid && resetN) w_next_state = (LATENCY == 1) ? S_RESPOND : S_BUSY;
      end
      S_BUSY: begin
        if (r_count == 4'd0) w_next_state = S_RESPOND;
      end
      S_RESPOND: begin
        if (respReady) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Lane selection: big-endian, so lower byte offsets sit in higher bit positions.
  always_comb begin
    w_mask  = {DATA_WIDTH{1'b1}};
    w_shift = 5'd0;
    case (w_cmd_size)
      2'd0: begin
        w_mask  = 32'h0000_00FF;
        w_shift = {~w_off, 3'b000};
      end
      2'd1: begin
        w_mask  = 32'h0000_FFFF;
        w_shift = {~w_off[1], 4'b0000};
      end
      default: begin
        w_mask  = {DATA_WIDTH{1'b1}};
        w_shift = 5'd0;
      end
    endcase
    w_old     = r_mem[w_index];
    w_lane    = (w_old >> w_shift) & w_mask;
    w_wr_word = (w_old & ~(w_mask << w_shift)) | ((w_cmd_wdata & w_mask) << w_shift);
    case (w_cmd_size)
      2'd0:    w_load = w_cmd_signed ? {{24{w_lane[7]}}, w_lane[7:0]} : w_lane;
      2'd1:    w_load = w_cmd_signed ? {{16{w_lane[15]}}, w_lane[15:0]} : w_lane;
      default: w_load = w_lane;
    endcase
    w_resp_data = (w_error || w_cmd_write) ? {DATA_WIDTH{1'b0}} : w_load;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Latency counter and registered response.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_count <= 4'd0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) r_count <= 4'(LATENCY > 1 ? LATENCY - 2 : 0);
      else if ((r_state == S_BUSY) && (r_count != 4'd0)) r_count <= r_count - 4'd1;
      if (w_commit) begin
        r_rdata <= w_resp_data;
        r_err   <= w_error;
      end else if ((r_state == S_RESPOND) && respReady) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  // Request capture on the accept handshake.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_write  <= reqWrite;
      r_addr   <= reqAddress[AW-1:0];
      r_size   <= reqSize;
      r_signed <= reqSigned;
      r_wdata  <= reqWriteData;
    end
  end

  // RAM write on the edge entering RESPOND; errored requests leave memory untouched.
  always_ff @(posedge clock) begin
    if (w_commit && w_cmd_write && !w_error) r_mem[w_index] <= w_wr_word;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - randomized and directed bench for data_memory_responder
module tb_data_memory_responder;

  logic        clock;
  logic        resetN;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [31:0] reqAddress;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic [31:0] reqWriteData;
  logic        respValid;
  logic        respReady;
  logic [31:0] respReadData;
  logic        respError;

  int n_compared = 0;
  int n_mismatched = 0;

  bit [7:0] model_bytes [4096];

  data_memory_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(10), .LATENCY(2)) dut (
    .clock(clock), .resetN(resetN),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddress(reqAddress), .reqSize(reqSize), .reqSigned(reqSigned),
    .reqWriteData(reqWriteData),
    .respValid(respValid), .respReady(respReady),
    .respReadData(respReadData), .respError(respError)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-addressed big-endian reference: byte k of an access sits at address a+k, MSB first.
  function automatic void model_access(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                                       input bit sg, input logic [31:0] wd,
                                       output logic [31:0] rd, output bit er);
    int n;
    int base;
    logic [31:0] v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = (sz == 2'd3) || ((a % n) != 0);
    rd = 32'h0;
    if (er) return;
    base = int'(a[11:0]);
    if (wr) begin
      for (int k = 0; k < n; k++) model_bytes[base + k] = 8'(wd >> (8 * (n - 1 - k)));
    end else begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v = (v << 8) | 32'(model_bytes[base + k]);
      if (sg && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
    end
  endfunction

  task automatic do_txn(input bit wr, input logic [31:0] a, input logic [1:0] sz, input bit sg,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output bit er, output int lat);
    int t;
    rd = 32'h0;
    er = 1'b0;
    lat = 0;
    @(negedge clock);
    reqValid = 1'b1;
    reqWrite = wr;
    reqAddress = a;
    reqSize = sz;
    reqSigned = sg;
    reqWriteData = wd;
    respReady = (hold == 0);
    t = 0;
    while (!reqReady && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!reqReady) begin
      check_eq("accept_timeout", 32'(reqReady), 32'd1);
      reqValid = 1'b0;
      return;
    end
    @(negedge clock);
    reqValid = 1'b0;
    reqWrite = 1'($urandom);
    reqAddress = $urandom;
    reqSize = 2'($urandom);
    reqWriteData = $urandom;
    lat = 1;
    while (!respValid && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    if (!respValid) begin
      check_eq("resp_timeout", 32'(respValid), 32'd1);
      return;
    end
    rd = respReadData;
    er = respError;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        check_eq("hold_valid", 32'(respValid), 32'd1);
        check_eq("hold_data", respReadData, rd);
        check_eq("hold_error", 32'(respError), 32'(er));
        check_eq("hold_req_ready", 32'(reqReady), 32'd0);
      end
      respReady = 1'b1;
    end
    @(negedge clock);
    check_eq("post_handshake_ready", 32'(reqReady), 32'd1);
    check_eq("post_handshake_valid", 32'(respValid), 32'd0);
  endtask

  task automatic txn_check(input string tag, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                           input bit sg, input logic [31:0] wd, input int hold);
    logic [31:0] rd, exp_rd;
    bit er, exp_er;
    int lat;
    do_txn(wr, a, sz, sg, wd, hold, rd, er, lat);
    model_access(wr, a, sz, sg, wd, exp_rd, exp_er);
    check_eq({tag, "_data"}, rd, exp_rd);
    check_eq({tag, "_error"}, 32'(er), 32'(exp_er));
    check_eq({tag, "_latency"}, 32'(lat), 32'd2);
  endtask

  initial begin
    logic [31:0] a;
    resetN = 1'b0;
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqAddress = 32'h40;
    reqSize = 2'd2;
    reqSigned = 1'b0;
    reqWriteData = 32'h5555_5555;
    respReady = 1'b1;

    @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("reset_req_ready", 32'(reqReady), 32'd0);
      check_eq("reset_resp_valid", 32'(respValid), 32'd0);
    end
    check_eq("reset_read_data", respReadData, 32'h0);
    check_eq("reset_error", 32'(respError), 32'd0);
    resetN = 1'b1;
    reqValid = 1'b0;
    @(negedge clock);
    check_eq("release_req_ready", 32'(reqReady), 32'd1);
    check_eq("release_resp_valid", 32'(respValid), 32'd0);

    txn_check("word_store", 1, 32'h40, 2'd2, 0, 32'hDEAD_BEEF, 0);
    txn_check("word_load", 0, 32'h40, 2'd2, 0, 32'h0, 0);

    txn_check("lane_init", 1, 32'h80, 2'd2, 0, 32'h1122_3344, 0);
    txn_check("byte_store", 1, 32'h81, 2'd0, 0, 32'hFFFF_FFAA, 0);
    txn_check("lane_word", 0, 32'h80, 2'd2, 0, 32'h0, 0);
    txn_check("byte_signed", 0, 32'h81, 2'd0, 1, 32'h0, 0);
    txn_check("byte_unsigned", 0, 32'h81, 2'd0, 0, 32'h0, 0);
    txn_check("half_signed", 0, 32'h82, 2'd1, 1, 32'h0, 0);

    txn_check("mis_word_store", 1, 32'h42, 2'd2, 0, 32'h0BAD_0BAD, 0);
    txn_check("mis_half_load", 0, 32'h43, 2'd1, 1, 32'h0, 0);
    txn_check("size3", 0, 32'h40, 2'd3, 0, 32'h0, 0);
    txn_check("mis_word_intact", 0, 32'h40, 2'd2, 0, 32'h0, 0);

    txn_check("backpressure", 0, 32'h80, 2'd2, 0, 32'h0, 5);

    txn_check("zero_init", 1, 32'h0, 2'd2, 0, 32'h600D_CAFE, 0);
    @(negedge clock);
    reqValid = 1'b1;
    reqWrite = 1'b1;
    reqAddress = 32'h0;
    reqSize = 2'd2;
    reqWriteData = 32'h1234_5678;
    check_eq("midreset_accept_ready", 32'(reqReady), 32'd1);
    @(negedge clock);
    reqValid = 1'b0;
    resetN = 1'b0;
    @(negedge clock);
    check_eq("midreset_resp_valid", 32'(respValid), 32'd0);
    resetN = 1'b1;
    @(negedge clock);
    check_eq("midreset_req_ready", 32'(reqReady), 32'd1);
    txn_check("midreset_word", 0, 32'h0, 2'd2, 0, 32'h0, 0);

    txn_check("wrap_store", 1, 32'h1000, 2'd2, 0, 32'hCAFE_F00D, 0);
    txn_check("wrap_load", 0, 32'h0, 2'd2, 0, 32'h0, 0);

    for (int i = 0; i < 16; i++) begin
      a = {20'($urandom), 12'(i * 4)};
      txn_check("rand_init", 1, a, 2'd2, 0, $urandom, 0);
    end
    for (int i = 0; i < 200; i++) begin
      a = {20'($urandom), 12'($urandom_range(0, 63))};
      txn_check("rand", 1'($urandom), a, 2'($urandom), 1'($urandom), $urandom,
                ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
